// File: rtl/fir_block_deserializer_pkg.sv
// fir_block_deserializer_pkg: shared lane limit and collector state type for the block deserializer
package fir_block_deserializer_pkg;
    localparam int MAX_LANES = 8;
    typedef enum logic {COLLECT, PAD_WAIT} deser_state_t;
endpackage

// File: rtl/fir_block_deserializer_if.sv
// fir_block_deserializer_if: serial sample stream in, L-lane block stream out
//   in_data/in_valid/in_ready  serial ready/valid sample stream
//   flush                      close the current partial block (zero-padded)
//   x/out_valid/out_ready      held block stream, lane i = sample Lk+i
//   out_mask                   bit i set when lane i carries a real sample
//   blk_cnt                    blocks emitted, wrapping
interface fir_block_deserializer_if #(
    parameter int INP_WIDTH = 16,
    parameter int L = 3,
    parameter int CNT_WIDTH = 16
);
    logic signed [INP_WIDTH-1:0] in_data;
    logic in_valid;
    logic in_ready;
    logic flush;
    logic signed [INP_WIDTH-1:0] x [L-1:0];
    logic out_valid;
    logic out_ready;
    logic [L-1:0] out_mask;
    logic [CNT_WIDTH-1:0] blk_cnt;
    modport master (
        output in_data, in_valid, flush, out_ready,
        input in_ready, x, out_valid, out_mask, blk_cnt
    );
    modport slave (
        input in_data, in_valid, flush, out_ready,
        output in_ready, x, out_valid, out_mask, blk_cnt
    );
endinterface

// File: rtl/fir_block_deserializer.sv
// fir_block_deserializer: packs a serial sample stream into held L-lane blocks for the parallel FIR
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  slave side of fir_block_deserializer_if (sample stream in, block stream out)
module fir_block_deserializer
    import fir_block_deserializer_pkg::*;
#(
    parameter int INP_WIDTH = 16,
    parameter int L = 3,
    parameter int CNT_WIDTH = 16
) (
    input logic clk,
    input logic rst,
    fir_block_deserializer_if.slave bus
);
    localparam int LW = $clog2(L);
    typedef logic signed [INP_WIDTH-1:0] sample_t;
    if (L < 2 || L > MAX_LANES) begin : g_bad_lanes
        $error("fir_block_deserializer: L must be in 2..%0d", MAX_LANES);
    end
    deser_state_t state, state_nxt;
    logic [LW-1:0] lane_cnt;
    sample_t col [L-2:0];
    sample_t blk [L-1:0];
    logic [L-1:0] pad_mask;
    logic rdy, slot_free, last, accept, full_emit, pad_emit;
    always_comb begin
        slot_free = !bus.out_valid || bus.out_ready;
        last = lane_cnt == LW'(L - 1);
        rdy = !rst && !bus.flush && state == COLLECT && (!last || slot_free);
        accept = bus.in_valid && rdy;
        full_emit = accept && last;
        // PAD_WAIT always holds a partial block, so it emits as soon as the slot opens
        pad_emit = slot_free && (state == PAD_WAIT || (bus.flush && lane_cnt != '0));
        state_nxt = (state == COLLECT && bus.flush && lane_cnt != '0 && !slot_free) ? PAD_WAIT :
                    (state == PAD_WAIT && slot_free) ? COLLECT : state;
        for (int i = 0; i < L; i++) pad_mask[i] = LW'(i) < lane_cnt;
        // the final lane comes straight from in_data; a padded block never fills it
        blk[L-1] = full_emit ? bus.in_data : '0;
        for (int i = 0; i < L - 1; i++) blk[i] = (full_emit || pad_mask[i]) ? col[i] : '0;
        bus.in_ready = rdy;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= COLLECT;
            lane_cnt <= '0;
            bus.out_valid <= 1'b0;
            bus.out_mask <= '0;
            bus.blk_cnt <= '0;
            for (int i = 0; i < L - 1; i++) col[i] <= '0;
            for (int i = 0; i < L; i++) bus.x[i] <= '0;
        end else begin
            state <= state_nxt;
            if (full_emit || pad_emit) begin
                bus.x <= blk;
                bus.out_mask <= full_emit ? '1 : pad_mask;
                bus.out_valid <= 1'b1;
                lane_cnt <= '0;
                bus.blk_cnt <= bus.blk_cnt + CNT_WIDTH'(1);
            end else begin
                if (bus.out_ready) bus.out_valid <= 1'b0;
                if (accept) begin
                    for (int i = 0; i < L - 1; i++)
                        if (lane_cnt == LW'(i)) col[i] <= bus.in_data;
                    lane_cnt <= lane_cnt + LW'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_fir_block_deserializer.sv
// tb_fir_block_deserializer: directed and randomised scoreboard bench for the block deserializer
module tb_fir_block_deserializer;
    typedef struct packed {
        logic [2:0][15:0] d;
        logic [2:0] m;
        logic [7:0] c;
    } blk_t;
    logic clk, rst;
    int n_chk = 0, n_err = 0;
    blk_t q[$];
    logic [15:0] cur [3];
    int cur_n = 0;
    logic [7:0] mcnt = '0;
    fir_block_deserializer_if #(.INP_WIDTH(16), .L(3), .CNT_WIDTH(8)) bif();
    fir_block_deserializer #(.INP_WIDTH(16), .L(3), .CNT_WIDTH(8)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bif)
    );
    initial clk = 1'b0;
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask
    task automatic send(input logic [15:0] v, input logic exp_rdy);
        bif.in_valid = 1'b1;
        bif.in_data = v;
        #3 chk("in_ready", bif.in_ready, exp_rdy);
        cyc();
    endtask
    task automatic push_blk(input logic [2:0] m);
        blk_t e;
        e.d = '0;
        for (int i = 0; i < cur_n; i++) e.d[i] = cur[i];
        mcnt++;
        e.m = m;
        e.c = mcnt;
        q.push_back(e);
        cur_n = 0;
    endtask
    always @(negedge clk) begin
        blk_t e;
        if (rst) begin
            q.delete();
            cur_n = 0;
            mcnt = '0;
        end else begin
            if (bif.out_valid && bif.out_ready) begin
                if (q.size() == 0) chk("sb_underflow", q.size(), 1);
                else begin
                    e = q.pop_front();
                    for (int i = 0; i < 3; i++) chk($sformatf("sb_lane%0d", i), bif.x[i], $signed(e.d[i]));
                    chk("sb_mask", bif.out_mask, e.m);
                    chk("sb_cnt", bif.blk_cnt, e.c);
                end
            end
            if (bif.in_valid && bif.in_ready) begin
                cur[cur_n] = bif.in_data;
                cur_n++;
                if (cur_n == 3) push_blk(3'b111);
            end else if (bif.flush && cur_n > 0) push_blk(3'((1 << cur_n) - 1));
        end
    end
    initial begin
        int acc, ncyc, k;
        logic took;
        logic [15:0] r;
        rst = 1'b1;
        bif.in_valid = 1'b0;
        bif.in_data = '0;
        bif.flush = 1'b0;
        bif.out_ready = 1'b1;
        cyc();
        chk("rst_x0", bif.x[0], 0);
        chk("rst_x2", bif.x[2], 0);
        chk("rst_valid", bif.out_valid, 0);
        chk("rst_mask", bif.out_mask, 0);
        chk("rst_cnt", bif.blk_cnt, 0);
        chk("rst_in_ready", bif.in_ready, 0);
        cyc();
        rst = 1'b0;
        for (int v = 1; v <= 9; v++) begin
            send(16'(v), 1'b1);
            if (v == 2) chk("lat_not_yet", bif.out_valid, 0);
            if (v == 3) chk("lat_valid", bif.out_valid, 1);
        end
        chk("t1_cnt", bif.blk_cnt, 3);
        bif.in_valid = 1'b0;
        cyc();
        bif.out_ready = 1'b0;
        send(16'd1, 1'b1);
        send(16'd2, 1'b1);
        send(16'd3, 1'b1);
        send(16'd4, 1'b1);
        send(16'd5, 1'b1);
        send(16'd6, 1'b0);
        send(16'd6, 1'b0);
        chk("hold_x0", bif.x[0], 1);
        chk("hold_x1", bif.x[1], 2);
        chk("hold_x2", bif.x[2], 3);
        chk("hold_valid", bif.out_valid, 1);
        bif.out_ready = 1'b1;
        send(16'd6, 1'b1);
        chk("reload_x0", bif.x[0], 4);
        chk("reload_x2", bif.x[2], 6);
        bif.in_valid = 1'b0;
        cyc();
        send(16'd10, 1'b1);
        send(16'hFFF5, 1'b1);
        bif.in_valid = 1'b0;
        bif.flush = 1'b1;
        #3 chk("flush_in_ready", bif.in_ready, 0);
        cyc();
        bif.flush = 1'b0;
        chk("flush_x0", bif.x[0], 10);
        chk("flush_x1", bif.x[1], -11);
        chk("flush_x2", bif.x[2], 0);
        chk("flush_mask", bif.out_mask, 3'b011);
        chk("flush_cnt", bif.blk_cnt, 6);
        bif.flush = 1'b1;
        cyc();
        bif.flush = 1'b0;
        chk("empty_flush_cnt", bif.blk_cnt, 6);
        chk("empty_flush_valid", bif.out_valid, 0);
        bif.out_ready = 1'b0;
        send(16'd20, 1'b1);
        send(16'd21, 1'b1);
        send(16'd22, 1'b1);
        send(16'd7, 1'b1);
        bif.in_valid = 1'b0;
        bif.flush = 1'b1;
        #3 chk("pad_flush_rdy", bif.in_ready, 0);
        cyc();
        bif.flush = 1'b0;
        #3 chk("pad_wait_rdy", bif.in_ready, 0);
        chk("pad_wait_cnt", bif.blk_cnt, 7);
        bif.flush = 1'b1;
        cyc();
        bif.flush = 1'b0;
        bif.out_ready = 1'b1;
        #3 chk("pad_wait_rdy2", bif.in_ready, 0);
        cyc();
        chk("pad_x0", bif.x[0], 7);
        chk("pad_x1", bif.x[1], 0);
        chk("pad_mask", bif.out_mask, 3'b001);
        chk("pad_cnt", bif.blk_cnt, 8);
        #3 chk("collect_rdy", bif.in_ready, 1);
        cyc();
        bif.out_ready = 1'b0;
        send(16'd30, 1'b1);
        send(16'd31, 1'b1);
        send(16'd32, 1'b1);
        send(16'd1, 1'b1);
        send(16'd2, 1'b1);
        bif.in_valid = 1'b0;
        #1 rst = 1'b1;
        #1 chk("arst_x0", bif.x[0], 0);
        chk("arst_x2", bif.x[2], 0);
        chk("arst_valid", bif.out_valid, 0);
        chk("arst_mask", bif.out_mask, 0);
        chk("arst_cnt", bif.blk_cnt, 0);
        chk("arst_in_ready", bif.in_ready, 0);
        cyc();
        cyc();
        rst = 1'b0;
        bif.out_ready = 1'b1;
        send(16'd5, 1'b1);
        send(16'd6, 1'b1);
        send(16'd7, 1'b1);
        chk("post_rst_x0", bif.x[0], 5);
        chk("post_rst_x1", bif.x[1], 6);
        chk("post_rst_x2", bif.x[2], 7);
        chk("post_rst_cnt", bif.blk_cnt, 1);
        k = 0;
        while (mcnt != 8'd255 && k < 2000) begin
            send(16'(k), 1'b1);
            k++;
        end
        chk("pre_wrap_cnt", bif.blk_cnt, 255);
        send(16'h8000, 1'b1);
        send(16'h7FFF, 1'b1);
        send(16'h0001, 1'b1);
        chk("wrap_cnt", bif.blk_cnt, 0);
        chk("wrap_x0", bif.x[0], -32768);
        chk("wrap_x1", bif.x[1], 32767);
        bif.in_valid = 1'b0;
        acc = 0;
        ncyc = 0;
        while (acc < 10000 && ncyc < 60000) begin
            if (!bif.in_valid) begin
                bif.in_valid = $urandom_range(0, 9) < 7;
                k = $urandom_range(0, 9);
                r = $urandom();
                bif.in_data = k == 0 ? 16'h8000 : k == 1 ? 16'h7FFF : r;
            end
            bif.out_ready = $urandom_range(0, 9) < 7;
            bif.flush = $urandom_range(0, 99) < 3;
            #3 took = bif.in_valid && bif.in_ready;
            if (took) acc++;
            cyc();
            if (took) bif.in_valid = 1'b0;
            ncyc++;
        end
        chk("rand_accepted", acc, 10000);
        bif.in_valid = 1'b0;
        bif.out_ready = 1'b1;
        bif.flush = 1'b1;
        cyc();
        bif.flush = 1'b0;
        k = 0;
        while ((q.size() > 0 || bif.out_valid) && k < 20) begin
            cyc();
            k++;
        end
        chk("sb_empty", q.size(), 0);
        chk("drained_valid", bif.out_valid, 0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
